ddr3_host_requester: RTL
========================

Name: ddr3_host_requester

Overview:
- Client-side traffic master for the DDR3 controller's host interface; it drives cmd/addr/din/sz/op and consumes dout/raddr/validout via read.
- On start it waits for ready, then issues NUM write commands carrying a deterministic pattern.
- It then issues NUM read commands and pops and checks every returned word against the expected address and data.
- It reports done, pass, an error count, the first failing address and a timeout flag; it is used for bring-up and as the bench stimulus source.

Parameters:
- ADDR_STEP, 8, address increment per command (one BL8 burst).
- SEED, 16'hA5C3, XOR seed for the data pattern.
- MAX_OUT, 16, maximum reads issued but not yet popped (kept below the 32-deep return FIFO).
- TIMEOUT, 4096, idle cycles allowed while draining before aborting.
- SZ_VAL, 2'b00, constant driven on sz.
- OP_VAL, 3'b000, constant driven on op.

Ports:
- clk  in  1  system clock (same clock as the controller)
- reset  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; ignored unless in IDLE
- base_addr  in  26  first address of the test; latched on start
- num  in  16  number of writes and of reads; 0 means immediate done with pass=1
- ready  in  1  controller initialisation complete
- notfull  in  1  controller command and input FIFOs can accept
- cmd  out  3  3'b010 write, 3'b001 read, 3'b000 NOP
- addr  out  26  command address
- din  out  16  write data
- sz  out  2  SZ_VAL
- op  out  3  OP_VAL
- validout  in  1  return FIFO non-empty
- raddr  in  26  returned address (head of return FIFO)
- dout  in  16  returned data (head of return FIFO)
- read  out  1  pops the return FIFO
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  high in DONE, held until the next start
- pass  out  1  valid while done: err_count==0 and no timeout
- err_count  out  16  mismatches seen; saturates at 16'hFFFF
- first_err_addr  out  26  raddr of the first mismatch
- timeout  out  1  drain aborted because TIMEOUT expired

Behaviour:
- Reset (reset==0 at a clk edge):
  - state IDLE; cmd=0, addr=0, din=0, read=0.
  - busy=0, done=0, pass=0, err_count=0, first_err_addr=0, timeout=0.
  - Internal counters cleared.
  - Reset mid-test aborts immediately; no further commands are issued.
- Command outputs are registered. The controller's put is combinational on cmd and notfull, so a command is accepted in any cycle where cmd!=0 and notfull==1.
- Issue rule: the block drives cmd!=0 for exactly one cycle per command, and only in a cycle where it samples notfull==1 on the previous edge.
  - Because notfull can fall in the same cycle, the block holds cmd, addr and din stable while notfull==0.
  - It advances to the next command only after a cycle with cmd!=0 and notfull==1.
  - No command is lost or duplicated.
- Data pattern: for the k-th address A = base_addr + k*ADDR_STEP (26-bit wrap), data = A[15:0] ^ SEED ^ {k[7:0], k[15:8]}.
- State machine:
  - IDLE: start -> clear err_count/first_err_addr/timeout/done, latch base_addr and num -> WAIT_RDY. If num==0 -> DONE with pass=1.
  - WAIT_RDY: cmd=NOP until ready==1 -> WRITE.
  - WRITE: issue num writes per the issue rule; the last write is accepted -> READ.
  - READ:
    - Issue num reads; a read may be issued only when outstanding < MAX_OUT.
    - The outstanding count increments on an accepted read and decrements on a pop; when both occur in the same cycle it is unchanged.
    - Pops run concurrently with issuing.
    - The last read is accepted -> DRAIN.
  - DRAIN: continue popping; when returned count == num -> DONE. If validout stays low for TIMEOUT consecutive cycles -> timeout=1, DONE.
  - DONE: done=1, pass = (err_count==0 && !timeout). start -> behaves as the IDLE start transition.
- Pop/check:
  - read = validout while in READ or DRAIN; this is combinational from validout, so at most one pop per cycle.
  - On each pop, compare raddr and dout with the expected entry for the returned-count index. Returns are in issue order.
  - On mismatch: increment err_count (saturating); if this is the first error, capture raddr into first_err_addr.
- Any validout seen in IDLE, WAIT_RDY or WRITE is not popped.
- The timeout counter resets on every pop and on entry to DRAIN.

Test Plan:
1. num=4, base=0, ideal controller model echoing the pattern -> writes at 0,8,16,24 with din = 16'hA5C3, 16'hA5CB^16'h0100, …; then 4 reads; done=1, pass=1, err_count=0.
2. notfull toggled low for 3 cycles mid-write with num=8 -> exactly 8 writes accepted, addresses strictly increasing by 8, none duplicated.
3. Model corrupts the return for the 3rd read (dout bit0 flipped) -> err_count=1, first_err_addr=26'd16, pass=0.
4. Model withholds returns, num=40 -> outstanding never exceeds 16, issuing stalls; after returns resume all 40 are popped and pass=1.
5. Model drops the final return -> timeout=1 after 4096 idle cycles, done=1, pass=0.
6. reset driven low during READ with num=32 -> next cycle cmd=0, read=0, busy=0, done=0; a subsequent start with num=0 gives done=1, pass=1.

Source files
------------

// File: rtl/ddr3_host_requester.sv
// Traffic master for the DDR3 controller host port: writes a seeded pattern over
// num bursts, reads them back and checks every returned word in issue order.
module ddr3_host_requester #(
    parameter int unsigned ADDR_STEP = 8,
    parameter logic [15:0] SEED      = 16'hA5C3,
    parameter int unsigned MAX_OUT   = 16,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [1:0]  SZ_VAL    = 2'b00,
    parameter logic [2:0]  OP_VAL    = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [25:0] base_addr,
    input  logic [15:0] num,
    input  logic        ready,
    input  logic        notfull,
    output logic [2:0]  cmd,
    output logic [25:0] addr,
    output logic [15:0] din,
    output logic [1:0]  sz,
    output logic [2:0]  op,
    input  logic        validout,
    input  logic [25:0] raddr,
    input  logic [15:0] dout,
    output logic        read,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [25:0] first_err_addr,
    output logic        timeout
);
    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_RD  = 3'b001;
    localparam logic [2:0] CMD_WR  = 3'b010;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    function automatic logic [25:0] addr_of(input logic [25:0] base, input logic [15:0] k);
        return base + 26'(k) * 26'(ADDR_STEP);
    endfunction

    function automatic logic [15:0] pat_of(input logic [25:0] a, input logic [15:0] k);
        return a[15:0] ^ SEED ^ {k[7:0], k[15:8]};
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [25:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [25:0] base_q, base_d;
    logic [15:0] num_q, num_d;
    logic [15:0] iss_q, iss_d;
    logic [15:0] ret_q, ret_d;
    logic [OW-1:0] out_q, out_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0] err_q, err_d;
    logic [25:0] ferr_q, ferr_d;
    logic        tflag_q, tflag_d;

    logic        acc, pop;
    logic [25:0] exp_addr;
    logic [15:0] exp_data;

    assign acc      = (cmd_q != CMD_NOP) && notfull;
    assign read     = validout && reset && (state_q == S_READ || state_q == S_DRAIN);
    assign pop      = read;
    assign exp_addr = addr_of(base_q, ret_q);
    assign exp_data = pat_of(exp_addr, ret_q);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        base_d  = base_q;
        num_d   = num_q;
        iss_d   = iss_q;
        ret_d   = ret_q;
        out_d   = out_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        tflag_d = tflag_q;

        // Returns arrive in issue order, so the returned count indexes the expected entry.
        if (pop) begin
            if (raddr != exp_addr || dout != exp_data) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (err_q == 16'd0) ferr_d = raddr;
            end
            ret_d = ret_q + 16'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num;
                    err_d   = '0;
                    ferr_d  = '0;
                    tflag_d = 1'b0;
                    iss_d   = '0;
                    ret_d   = '0;
                    out_d   = '0;
                    tmo_d   = '0;
                    state_d = (num == 16'd0) ? S_DONE : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (ready) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (acc) iss_d = iss_q + 16'd1;
                // A pending command is held unchanged until the controller takes it.
                if (cmd_q == CMD_NOP || acc) begin
                    cmd_d = CMD_NOP;
                    if (iss_d == num_q) begin
                        state_d = S_READ;
                        iss_d   = '0;
                    end else if (notfull) begin
                        cmd_d  = CMD_WR;
                        addr_d = addr_of(base_q, iss_d);
                        din_d  = pat_of(addr_d, iss_d);
                    end
                end
            end
            S_READ: begin
                if (acc) iss_d = iss_q + 16'd1;
                if (acc && !pop)
                    out_d = out_q + OW'(1);
                else if (!acc && pop && out_q != '0)
                    out_d = out_q - OW'(1);
                if (cmd_q == CMD_NOP || acc) begin
                    cmd_d = CMD_NOP;
                    if (iss_d == num_q) begin
                        state_d = S_DRAIN;
                        tmo_d   = '0;
                    end else if (notfull && out_d < OW'(MAX_OUT)) begin
                        cmd_d  = CMD_RD;
                        addr_d = addr_of(base_q, iss_d);
                        din_d  = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (pop) begin
                    tmo_d = '0;
                    if (ret_d == num_q) state_d = S_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tflag_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            din_q   <= '0;
            base_q  <= '0;
            num_q   <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            out_q   <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            base_q  <= base_d;
            num_q   <= num_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            out_q   <= out_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            tflag_q <= tflag_d;
        end
    end

    assign cmd            = cmd_q;
    assign addr           = addr_q;
    assign din            = din_q;
    assign sz             = SZ_VAL;
    assign op             = OP_VAL;
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == 16'd0) && !tflag_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign timeout        = tflag_q;

endmodule
